// File: rtl/riscv_defines.sv
// Shared core definitions: data width, LSU access sizes, LSU FSM states and
// the alignment rule used to reject requests before they reach memory.
package riscv_defines;

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT_GNT,
    LSU_WAIT_RVALID
  } lsu_state_e;

  // A request is rejected if its address is not naturally aligned to its
  // size; the reserved size encoding 2'b11 is always rejected.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
    logic bad;
    case (size)
      LSU_BYTE: bad = 1'b0;
      LSU_HALF: bad = off[0];
      LSU_WORD: bad = (off != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane handling for the LSU: byte enables and store-data lane
// shifting on the request side, load-data extraction and extension on the
// response side.
module lsu_data_align
  import riscv_defines::*;
(
  input  logic [1:0]            req_size_i,
  input  logic [1:0]            req_off_i,
  input  logic [WORD_WIDTH-1:0] req_wdata_i,
  output logic [3:0]            be_o,
  output logic [WORD_WIDTH-1:0] wdata_o,
  input  logic [1:0]            rsp_size_i,
  input  logic [1:0]            rsp_off_i,
  input  logic                  rsp_sign_ext_i,
  input  logic [WORD_WIDTH-1:0] rsp_rdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] rdata_shift;

  // Byte enables follow the access size, shifted to the addressed lane.
  always_comb begin
    be_o = 4'b0000;
    case (req_size_i)
      LSU_BYTE: be_o = 4'b0001 << req_off_i;
      LSU_HALF: be_o = 4'b0011 << {req_off_i[1], 1'b0};
      LSU_WORD: be_o = 4'b1111;
      default:  be_o = 4'b0000;
    endcase
  end

  // Store data moves from the low lanes up to the addressed lane.
  assign wdata_o = req_wdata_i << {req_off_i, 3'b000};

  // Load data moves down to bit 0, then is masked and extended to the size.
  // Word accesses are always aligned, so the shift is a no-op for them.
  always_comb begin
    rdata_shift = rsp_rdata_i >> {rsp_off_i, 3'b000};
    case (rsp_size_i)
      LSU_BYTE: rdata_o = {{24{rsp_sign_ext_i & rdata_shift[7]}}, rdata_shift[7:0]};
      LSU_HALF: rdata_o = {{16{rsp_sign_ext_i & rdata_shift[15]}}, rdata_shift[15:0]};
      default:  rdata_o = rdata_shift;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one EX-stage access at a time, drives
// the data memory req/gnt/rvalid handshake from registered state, and stalls
// the pipeline until the response arrives.
module lsu_ctrl #(
  parameter int unsigned WORD_WIDTH = riscv_defines::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [WORD_WIDTH-1:0] lsu_addr_i,
  input  logic [WORD_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_stall_o,
  output logic                  lsu_rvalid_o,
  output logic [WORD_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  data_req_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  input  logic                  data_rvalid_i,
  input  logic                  data_gnt_i
);
  import riscv_defines::*;

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [1:0]            off_q, off_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;

  logic [3:0]            be_new;
  logic [WORD_WIDTH-1:0] wdata_new;
  logic [WORD_WIDTH-1:0] rdata_ext;
  logic                  misaligned;

  assign misaligned = lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);

  // Request side is aligned from the live EX inputs so the lane-shifted
  // values can be captured in the accept cycle; response side uses the
  // captured size/offset because EX may have moved on.
  lsu_data_align u_align (
    .req_size_i     (lsu_size_i),
    .req_off_i      (lsu_addr_i[1:0]),
    .req_wdata_i    (lsu_wdata_i),
    .be_o           (be_new),
    .wdata_o        (wdata_new),
    .rsp_size_i     (size_q),
    .rsp_off_i      (off_q),
    .rsp_sign_ext_i (sign_q),
    .rsp_rdata_i    (data_rdata_i),
    .rdata_o        (rdata_ext)
  );

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, capture and pipeline-facing handshake outputs.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    off_d        = off_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    lsu_stall_o  = 1'b0;
    lsu_rvalid_o = 1'b0;
    lsu_err_o    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          if (misaligned) begin
            lsu_err_o = 1'b1;
          end else begin
            we_d        = lsu_we_i;
            size_d      = lsu_size_i;
            sign_d      = lsu_sign_ext_i;
            off_d       = lsu_addr_i[1:0];
            addr_d      = {lsu_addr_i[WORD_WIDTH-1:2], 2'b00};
            be_d        = be_new;
            wdata_d     = wdata_new;
            lsu_stall_o = 1'b1;
            state_d     = LSU_WAIT_GNT;
          end
        end
      end
      LSU_WAIT_GNT: begin
        lsu_stall_o = 1'b1;
        if (data_gnt_i) state_d = LSU_WAIT_RVALID;
      end
      LSU_WAIT_RVALID: begin
        if (data_rvalid_i) begin
          lsu_rvalid_o = 1'b1;
          state_d      = LSU_IDLE;
        end else begin
          lsu_stall_o = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  assign data_req_o   = (state_q == LSU_WAIT_GNT);
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  // Load data is only presented in the completing cycle of a load.
  assign lsu_rdata_o  = (lsu_rvalid_o && !we_q) ? rdata_ext : '0;

endmodule
